// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, frame geometry, common command bytes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ps2_pkg;

  // Host transmitter states.
  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    ACK,
    WAIT_IDLE
  } ps2_tx_state_t;

  // Bits shifted after the start bit: 8 data + odd parity + stop.
  localparam int PS2_FRAME_BITS = 10;

  // Commonly used command and response bytes.
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RESP_ACK     = 8'hFA;

  // Builds the shift-register image of a host frame. LSB goes out first, so
  // data bit 0 is at index 0, then odd parity, then the stop bit.
  function automatic logic [PS2_FRAME_BITS-1:0] ps2_tx_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 pad conditioning: 2-FF synchronisers, FILTER_LEN-sample glitch filter, registered clock fall strobe.
// Latency: sync outputs 2 cycles; filtered levels and fall_edge_o 2 + FILTER_LEN cycles after a pad change.
// Backpressure: none; free-running, one fall_edge_o pulse per accepted 1->0 clock transition.
//
// Ports:
//   clk, reset_n      system clock, asynchronous active-low reset
//   ps2_clk_i/data_i  raw asynchronous pad levels
//   clk_sync_o        synchronised (unfiltered) clock level
//   data_sync_o       synchronised (unfiltered) data level
//   data_filt_o       filtered data level
//   fall_edge_o       one-cycle pulse when the filtered clock goes 1 -> 0
module ps2_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_sync_o,
  output logic data_sync_o,
  output logic data_filt_o,
  output logic fall_edge_o
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);

  // Index 1 is the metastability-safe stage.
  logic [1:0]    clk_meta_q, data_meta_q;
  logic          clk_filt_q, clk_filt_d;
  logic          data_filt_q, data_filt_d;
  logic [FW-1:0] clk_cnt_q, clk_cnt_d;
  logic [FW-1:0] data_cnt_q, data_cnt_d;
  logic          fall_q, fall_d;

  // The counters track consecutive samples that disagree with the current
  // filtered level; the level only flips on the FILTER_LEN-th such sample,
  // so any shorter run is dropped without a trace.
  always_comb begin
    clk_filt_d = clk_filt_q;
    clk_cnt_d  = '0;
    if (clk_meta_q[1] != clk_filt_q) begin
      if (clk_cnt_q == FLT_LAST) begin
        clk_filt_d = clk_meta_q[1];
      end else begin
        clk_cnt_d = clk_cnt_q + FW'(1);
      end
    end

    data_filt_d = data_filt_q;
    data_cnt_d  = '0;
    if (data_meta_q[1] != data_filt_q) begin
      if (data_cnt_q == FLT_LAST) begin
        data_filt_d = data_meta_q[1];
      end else begin
        data_cnt_d = data_cnt_q + FW'(1);
      end
    end

    fall_d = clk_filt_q & ~clk_filt_d;
  end

  // Idle bus is high, so everything resets to 1 to avoid a phantom edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_meta_q  <= 2'b11;
      data_meta_q <= 2'b11;
      clk_filt_q  <= 1'b1;
      data_filt_q <= 1'b1;
      clk_cnt_q   <= '0;
      data_cnt_q  <= '0;
      fall_q      <= 1'b0;
    end else begin
      clk_meta_q  <= {clk_meta_q[0], ps2_clk_i};
      data_meta_q <= {data_meta_q[0], ps2_data_i};
      clk_filt_q  <= clk_filt_d;
      data_filt_q <= data_filt_d;
      clk_cnt_q   <= clk_cnt_d;
      data_cnt_q  <= data_cnt_d;
      fall_q      <= fall_d;
    end
  end

  assign clk_sync_o  = clk_meta_q[1];
  assign data_sync_o = data_meta_q[1];
  assign data_filt_o = data_filt_q;
  assign fall_edge_o = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: request-to-send, bit serialisation on device clock, ACK check.
// Latency: clk_oe 1 cycle after accept; data_oe INHIBIT_CYCLES+1 after accept; bit update 2+FILTER_LEN+1 after pad fall.
// Backpressure: tx_ready only in IDLE; send_req while busy is ignored, not queued.
//
// Ports:
//   clk, reset_n              system clock, asynchronous active-low reset
//   tx_data, send_req         byte and request; accepted when send_req & tx_ready at a clock edge
//   tx_ready, tx_busy         IDLE indicator and its complement (receiver gate)
//   tx_done, tx_error         one-cycle result pulses (ACK=0 / timeout or ACK=1)
//   ps2_clk_in, ps2_data_in   raw open-drain pad levels
//   ps2_clk_oe, ps2_data_oe   1 pulls the respective line low
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int FILTER_LEN     = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] tx_data,
  input  logic       send_req,
  output logic       tx_ready,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] INHIBIT_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    BITS_ALL     = 4'(PS2_FRAME_BITS);
  localparam logic [3:0]    BITS_LAST    = 4'(PS2_FRAME_BITS - 1);

  logic clk_sync, data_sync, data_filt, fall_edge;

  ps2_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_line_filter (
    .clk         (clk),
    .reset_n     (reset_n),
    .ps2_clk_i   (ps2_clk_in),
    .ps2_data_i  (ps2_data_in),
    .clk_sync_o  (clk_sync),
    .data_sync_o (data_sync),
    .data_filt_o (data_filt),
    .fall_edge_o (fall_edge)
  );

  ps2_tx_state_t               state_q;
  logic [PS2_FRAME_BITS-1:0]   shreg_q;
  logic [3:0]                  bitcnt_q;
  logic [CW-1:0]               cnt_q;
  logic [CW-1:0]               cnt_inc;
  logic                        clk_oe_q, data_oe_q;
  logic                        done_q, err_q;
  logic                        ack_ok_q;
  logic                        inhibit_end, timeout_hit;

  // One counter serves both the inhibit hold and the device-wait timeout;
  // they never overlap since INHIBIT is the only state that times the hold.
  assign cnt_inc     = cnt_q + CW'(1);
  assign inhibit_end = (cnt_q == INHIBIT_LAST);
  assign timeout_hit = (cnt_q == TIMEOUT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bitcnt_q  <= '0;
      cnt_q     <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ack_ok_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      cnt_q  <= cnt_inc;

      unique case (state_q)
        IDLE: begin
          clk_oe_q  <= 1'b0;
          data_oe_q <= 1'b0;
          cnt_q     <= '0;
          if (send_req) begin
            shreg_q  <= ps2_tx_frame(tx_data);
            bitcnt_q <= '0;
            clk_oe_q <= 1'b1;
            state_q  <= INHIBIT;
          end
        end

        // Our own clock pull-down produces a filtered fall here; it must not
        // restart the hold, so fall_edge is deliberately ignored.
        INHIBIT: begin
          if (inhibit_end) begin
            data_oe_q <= 1'b1;
            cnt_q     <= '0;
            state_q   <= REQ;
          end
        end

        // Data already low: releasing the clock turns this into the start bit.
        REQ: begin
          clk_oe_q <= 1'b0;
          cnt_q    <= '0;
          state_q  <= SHIFT;
        end

        SHIFT: begin
          if (fall_edge) begin
            data_oe_q <= ~shreg_q[0];
            shreg_q   <= {1'b0, shreg_q[PS2_FRAME_BITS-1:1]};
            cnt_q     <= '0;
            if (bitcnt_q < BITS_ALL) begin
              bitcnt_q <= bitcnt_q + 4'd1;
            end
            if (bitcnt_q == BITS_LAST) begin
              state_q <= ACK;
            end
          end else if (timeout_hit) begin
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            err_q     <= 1'b1;
            cnt_q     <= '0;
            state_q   <= IDLE;
          end
        end

        ACK: begin
          if (fall_edge) begin
            ack_ok_q <= ~data_filt;
            cnt_q    <= '0;
            state_q  <= WAIT_IDLE;
          end else if (timeout_hit) begin
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            err_q     <= 1'b1;
            cnt_q     <= '0;
            state_q   <= IDLE;
          end
        end

        // Result is held back until the device releases both lines so the
        // receiver never sees the tail of the ACK as a frame start.
        WAIT_IDLE: begin
          if (clk_sync && data_sync) begin
            done_q  <= ack_ok_q;
            err_q   <= ~ack_ok_q;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else if (fall_edge) begin
            cnt_q <= '0;
          end else if (timeout_hit) begin
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            err_q     <= 1'b1;
            cnt_q     <= '0;
            state_q   <= IDLE;
          end
        end

        default: begin
          clk_oe_q  <= 1'b0;
          data_oe_q <= 1'b0;
          cnt_q     <= '0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign tx_ready = (state_q == IDLE);
  assign tx_busy  = (state_q != IDLE);
  assign tx_done  = done_q;
  assign tx_error = err_q;

  // Gated by reset_n so the pads are released the instant reset asserts.
  assign ps2_clk_oe  = clk_oe_q & reset_n;
  assign ps2_data_oe = data_oe_q & reset_n;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model.
// Latency: n/a.
// Backpressure: n/a.
module tb_ps2_host_tx;

  localparam int INH  = 50;
  localparam int TMO  = 400;
  localparam int FLT  = 4;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       send_req = 1'b0;
  logic       tx_ready, tx_busy, tx_done, tx_error;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       ps2_clk_in, ps2_data_in;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  int checks = 0;
  int errors = 0;
  int done_pulses = 0;
  int err_pulses = 0;
  int pulse_rdy_bad = 0;
  int oe_run = 0;
  int last_run = 0;

  // Open-drain wired-AND of host and device.
  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO),
    .FILTER_LEN     (FLT)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .tx_data     (tx_data),
    .send_req    (send_req),
    .tx_ready    (tx_ready),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_error    (tx_error),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  // Pulse counters and host clock-low run length.
  always @(negedge clk) begin
    if (tx_done) done_pulses++;
    if (tx_error) err_pulses++;
    if ((tx_done || tx_error) && !tx_ready) pulse_rdy_bad++;
    if (ps2_clk_oe) begin
      oe_run++;
    end else begin
      if (oe_run > 0) last_run = oe_run;
      oe_run = 0;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic start_tx(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    send_req = 1'b1;
    @(posedge clk);
    #1;
    send_req = 1'b0;
  endtask

  // Device side: waits for the request-to-send, samples the start bit, then
  // clocks 10 bits sampling on rising edges, then clocks the ACK bit.
  task automatic device_frame(input logic ack_bit, input int glitch_at, input int abort_at,
                              output logic [10:0] bits, output logic started);
    bits    = '0;
    started = 1'b0;
    for (int n = 0; n < 2000 && !started; n++) begin
      @(negedge clk);
      if (ps2_clk_in && !ps2_data_in) started = 1'b1;
    end
    if (!started) return;
    bits[0] = ps2_data_in;
    repeat (HALF) @(negedge clk);
    for (int i = 1; i <= 10; i++) begin
      dev_clk_low = 1'b1;
      if (i == abort_at) begin
        repeat (HALF / 2) @(negedge clk);
        return;
      end
      repeat (HALF) @(negedge clk);
      bits[i]     = ps2_data_in;
      dev_clk_low = 1'b0;
      if (i == 10) dev_data_low = !ack_bit;
      if (i == glitch_at) begin
        repeat (5) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (FLT - 1) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (HALF - 5 - (FLT - 1)) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (HALF / 2) @(negedge clk);
    dev_data_low = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic wait_ready();
    for (int n = 0; n < 200 && !tx_ready; n++) @(negedge clk);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", tx_ready); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", tx_busy); end
    checks++; if (tx_done !== 1'b0 || tx_error !== 1'b0) begin errors++; $display("FAIL reset_pulses got done=%b err=%b want 0 0", tx_done, tx_error); end
    checks++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin errors++; $display("FAIL reset_oe got clk=%b data=%b want 0 0", ps2_clk_oe, ps2_data_oe); end
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++; if (tx_ready !== 1'b1 || ps2_clk_oe !== 1'b0) begin errors++; $display("FAIL post_reset_idle got ready=%b clk_oe=%b want 1 0", tx_ready, ps2_clk_oe); end
  endtask

  task automatic test_set_leds();
    int d0, e0, r0, k;
    logic [10:0] bits;
    logic started;
    d0 = done_pulses; e0 = err_pulses; r0 = pulse_rdy_bad;
    start_tx(8'hED);
    checks++; if (tx_ready !== 1'b0 || tx_busy !== 1'b1) begin errors++; $display("FAIL accept_ready got ready=%b busy=%b want 0 1", tx_ready, tx_busy); end
    checks++; if (ps2_clk_oe !== 1'b1) begin errors++; $display("FAIL accept_clk_oe got %b want 1", ps2_clk_oe); end
    k = 0;
    while (!ps2_data_oe && k < 200) begin @(negedge clk); k++; end
    checks++; if (k !== INH + 1) begin errors++; $display("FAIL data_oe_latency got %0d want %0d", k, INH + 1); end
    checks++; if (ps2_clk_oe !== 1'b1) begin errors++; $display("FAIL req_clk_oe got %b want 1", ps2_clk_oe); end
    @(negedge clk);
    checks++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b1) begin errors++; $display("FAIL shift_entry got clk_oe=%b data_oe=%b want 0 1", ps2_clk_oe, ps2_data_oe); end
    device_frame(1'b0, 0, 0, bits, started);
    checks++; if (started !== 1'b1) begin errors++; $display("FAIL ed_start got %b want 1", started); end
    checks++; if (bits !== 11'h7DA) begin errors++; $display("FAIL ed_bits got %h want 7da", bits); end
    wait_ready();
    checks++; if (done_pulses - d0 !== 1) begin errors++; $display("FAIL ed_done got %0d want 1", done_pulses - d0); end
    checks++; if (err_pulses - e0 !== 0) begin errors++; $display("FAIL ed_error got %0d want 0", err_pulses - e0); end
    checks++; if (last_run !== INH + 1) begin errors++; $display("FAIL ed_clk_hold got %0d want %0d", last_run, INH + 1); end
    checks++; if (pulse_rdy_bad !== r0) begin errors++; $display("FAIL ed_ready_at_pulse got %0d want %0d", pulse_rdy_bad, r0); end
    checks++; if (tx_ready !== 1'b1 || ps2_data_oe !== 1'b0) begin errors++; $display("FAIL ed_idle got ready=%b data_oe=%b want 1 0", tx_ready, ps2_data_oe); end
  endtask

  task automatic test_parity();
    logic [7:0]  vec_b [2];
    logic [10:0] vec_f [2];
    int d0;
    logic [10:0] bits;
    logic started;
    vec_b[0] = 8'h02; vec_f[0] = 11'h404;
    vec_b[1] = 8'h00; vec_f[1] = 11'h600;
    for (int v = 0; v < 2; v++) begin
      d0 = done_pulses;
      start_tx(vec_b[v]);
      // A request while busy must be ignored and must not change the byte.
      send_req = 1'b1;
      tx_data  = 8'hFF;
      repeat (20) @(negedge clk);
      checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL parity_busy[%0d] got %b want 1", v, tx_busy); end
      send_req = 1'b0;
      device_frame(1'b0, 0, 0, bits, started);
      checks++; if (bits !== vec_f[v]) begin errors++; $display("FAIL parity_bits[%0d] got %h want %h", v, bits, vec_f[v]); end
      wait_ready();
      checks++; if (done_pulses - d0 !== 1) begin errors++; $display("FAIL parity_done[%0d] got %0d want 1", v, done_pulses - d0); end
    end
  endtask

  task automatic test_ack_error();
    int d0, e0;
    logic [10:0] bits;
    logic started;
    d0 = done_pulses; e0 = err_pulses;
    start_tx(8'hED);
    device_frame(1'b1, 0, 0, bits, started);
    wait_ready();
    checks++; if (bits !== 11'h7DA) begin errors++; $display("FAIL nack_bits got %h want 7da", bits); end
    checks++; if (err_pulses - e0 !== 1) begin errors++; $display("FAIL nack_error got %0d want 1", err_pulses - e0); end
    checks++; if (done_pulses - d0 !== 0) begin errors++; $display("FAIL nack_done got %0d want 0", done_pulses - d0); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL nack_ready got %b want 1", tx_ready); end
  endtask

  task automatic test_timeout();
    int d0, e0, k, t;
    d0 = done_pulses; e0 = err_pulses;
    start_tx(8'hFF);
    k = 0;
    while (!(ps2_data_oe && !ps2_clk_oe) && k < 200) begin @(negedge clk); k++; end
    t = 1;
    while (!tx_error && t < TMO + 50) begin @(negedge clk); t++; end
    checks++; if (t !== TMO + 1) begin errors++; $display("FAIL timeout_cycles got %0d want %0d", t, TMO + 1); end
    checks++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin errors++; $display("FAIL timeout_oe got clk=%b data=%b want 0 0", ps2_clk_oe, ps2_data_oe); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL timeout_ready got %b want 1", tx_ready); end
    @(negedge clk);
    checks++; if (tx_error !== 1'b0) begin errors++; $display("FAIL timeout_pulse_width got %b want 0", tx_error); end
    checks++; if (err_pulses - e0 !== 1 || done_pulses - d0 !== 0) begin errors++; $display("FAIL timeout_counts got err=%0d done=%0d want 1 0", err_pulses - e0, done_pulses - d0); end
  endtask

  task automatic test_glitch();
    int d0, e0;
    logic [10:0] bits;
    logic started;
    d0 = done_pulses; e0 = err_pulses;
    start_tx(8'hED);
    device_frame(1'b0, 4, 0, bits, started);
    wait_ready();
    checks++; if (bits !== 11'h7DA) begin errors++; $display("FAIL glitch_bits got %h want 7da", bits); end
    checks++; if (done_pulses - d0 !== 1 || err_pulses - e0 !== 0) begin errors++; $display("FAIL glitch_result got done=%0d err=%0d want 1 0", done_pulses - d0, err_pulses - e0); end
  endtask

  task automatic test_reset_mid_frame();
    int d0, e0;
    logic [10:0] bits;
    logic started;
    d0 = done_pulses; e0 = err_pulses;
    start_tx(8'hED);
    device_frame(1'b0, 0, 5, bits, started);
    // Fall 5 presents data bit 4 of 0xED, which is 0, so data is pulled low.
    checks++; if (ps2_data_oe !== 1'b1) begin errors++; $display("FAIL midframe_data_oe got %b want 1", ps2_data_oe); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (ps2_clk_oe !== 1'b0 || ps2_data_oe !== 1'b0) begin errors++; $display("FAIL midreset_oe got clk=%b data=%b want 0 0", ps2_clk_oe, ps2_data_oe); end
    checks++; if (tx_ready !== 1'b1 || tx_busy !== 1'b0) begin errors++; $display("FAIL midreset_state got ready=%b busy=%b want 1 0", tx_ready, tx_busy); end
    dev_clk_low = 1'b0;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++; if (done_pulses - d0 !== 0 || err_pulses - e0 !== 0) begin errors++; $display("FAIL midreset_pulses got done=%0d err=%0d want 0 0", done_pulses - d0, err_pulses - e0); end
    start_tx(8'hED);
    device_frame(1'b0, 0, 0, bits, started);
    wait_ready();
    checks++; if (bits !== 11'h7DA) begin errors++; $display("FAIL postreset_bits got %h want 7da", bits); end
    checks++; if (done_pulses - d0 !== 1) begin errors++; $display("FAIL postreset_done got %0d want 1", done_pulses - d0); end
  endtask

  task automatic test_back_to_back();
    int d0, r0;
    logic [10:0] bits;
    logic started;
    d0 = done_pulses; r0 = pulse_rdy_bad;
    start_tx(8'hED);
    // Held through the whole first frame: ignored while busy, accepted on the done-pulse edge.
    tx_data  = 8'h02;
    send_req = 1'b1;
    device_frame(1'b0, 0, 0, bits, started);
    checks++; if (bits !== 11'h7DA) begin errors++; $display("FAIL b2b_first_bits got %h want 7da", bits); end
    checks++; if (done_pulses - d0 !== 1) begin errors++; $display("FAIL b2b_first_done got %0d want 1", done_pulses - d0); end
    checks++; if (tx_busy !== 1'b1 || ps2_clk_oe !== 1'b1) begin errors++; $display("FAIL b2b_reaccept got busy=%b clk_oe=%b want 1 1", tx_busy, ps2_clk_oe); end
    send_req = 1'b0;
    device_frame(1'b0, 0, 0, bits, started);
    wait_ready();
    checks++; if (bits !== 11'h404) begin errors++; $display("FAIL b2b_second_bits got %h want 404", bits); end
    checks++; if (done_pulses - d0 !== 2) begin errors++; $display("FAIL b2b_second_done got %0d want 2", done_pulses - d0); end
    checks++; if (pulse_rdy_bad !== r0) begin errors++; $display("FAIL b2b_ready_at_pulse got %0d want %0d", pulse_rdy_bad, r0); end
  endtask

  initial begin
    test_reset();
    test_set_leds();
    test_parity();
    test_ack_error();
    test_timeout();
    test_glitch();
    test_reset_mid_frame();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter. It accepts one byte per handshake from a command source, such as the keyboard-indicator sequencer that sends 0xED followed by the LED byte. It serialises the byte onto the open-drain PS/2 clock/data pair using the host-request protocol and reports the device acknowledge. It sits between the command sequencers and the PS/2 pads, alongside the PS/2 receiver, which must ignore the bus while this block is busy.

## Interface
- INHIBIT_CYCLES, 5000: clock-low request hold time (≥100 µs; 5000 = 100 µs at 50 MHz).
- TIMEOUT_CYCLES, 750000: max cycles spent in any wait for the device (15 ms at 50 MHz).
- FILTER_LEN, 4: consecutive equal synchronised samples required to accept a new PS/2 clock level.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- tx_data  in  8  byte to send; sampled on the accept edge.
- send_req  in  1  request; held high until accepted.
- tx_ready  out  1  high only in IDLE; accept = send_req & tx_ready at a rising clk edge.
- tx_busy  out  1  high in every state except IDLE; the receiver discards frames while high.
- tx_done  out  1  one-cycle pulse: device ACK received (ACK bit = 0).
- tx_error  out  1  one-cycle pulse: timeout or ACK bit = 1.
- ps2_clk_in  in  1  raw pad clock (asynchronous).
- ps2_data_in  in  1  raw pad data (asynchronous).
- ps2_clk_oe  out  1  1 = pull clock low.
- ps2_data_oe  out  1  1 = pull data low.

## Operation
- Reset values: tx_ready=1 (IDLE), tx_busy=0, tx_done=0, tx_error=0, both oe=0, shift register=0, counters=0.
- Line conditioning:
  - 2-FF synchronisers on both pads.
  - Clock level changes only after FILTER_LEN equal samples.
  - fall_edge = filtered clock 1→0; one cycle per edge.
- States:
  - **IDLE**: oe=0. On accept, latch {stop=1, parity, tx_data} into an 10-bit shift register (LSB = data bit 0). Parity = ~^tx_data (odd). Go to INHIBIT.
  - **INHIBIT**: clk_oe=1 for INHIBIT_CYCLES, then go to REQ.
  - **REQ**: one cycle with data_oe=1 and clk_oe=1, then go to SHIFT. In SHIFT, clk_oe=0 and data_oe stays 1; this is the start bit.
  - **SHIFT**: on each fall_edge, data_oe ← ~shreg[0], then shift right and increment the bit counter. Edges 1–8 present data bits 0–7, edge 9 presents parity, edge 10 presents the stop bit (data_oe=0). After edge 10, go to ACK.
  - **ACK**: on fall_edge, sample filtered data. 0 → WAIT_IDLE with ack_ok. 1 → WAIT_IDLE with ack_bad.
  - **WAIT_IDLE**: wait until synchronised clock and data are both 1. Then pulse tx_done (ack_ok) or tx_error (ack_bad) and return to IDLE.
- Timeout counter:
  - Cleared on every state change and every fall_edge.
  - In SHIFT, ACK and WAIT_IDLE, reaching TIMEOUT_CYCLES−1 forces oe=0, pulses tx_error, and returns to IDLE.
  - INHIBIT cannot time out.
- send_req while not in IDLE is ignored; it is not queued.
- Bus contention is not detected. The device is expected to abort its own frame when the clock is inhibited.

## Timing
- Accept edge N: tx_ready=0 and clk_oe=1 from N+1.
- data_oe rises INHIBIT_CYCLES+1 cycles after accept. clk_oe falls one cycle after that.
- Data update latency from a raw pad falling edge: 2 sync + FILTER_LEN cycles + 1 register cycle. This must stay below half a PS/2 period (≥30 µs).
- tx_done/tx_error fall one cycle after they pulse. tx_ready=1 in the same cycle as the pulse, so the next accept can happen on that edge.
- Asynchronous reset mid-frame releases both lines immediately (oe=0 combinationally from reset) and returns to IDLE. No done/error pulse is issued.
- Counter widths: $clog2 of the larger of INHIBIT_CYCLES and TIMEOUT_CYCLES. The bit counter is 4 bits and saturates at 10.

## Structure
- Package ps2_pkg:
  - ps2_tx_state_t enum: IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE.
  - Constants: PS2_FRAME_BITS=10 (data+parity+stop), CMD_SET_LEDS=8'hED, CMD_RESET=8'hFF, RESP_ACK=8'hFA.
- Sub-module ps2_line_filter (synchroniser, glitch filter, fall_edge output). It is shared with the PS/2 receiver.

## Test plan
- tx_data=0xED with a device model that clocks at 12.5 kHz and ACKs. Expect:
  - clock held low ≥100 µs;
  - bits sampled on device rising edges: 0, then 1,0,1,1,0,1,1,1, parity 1, stop 1;
  - one tx_done pulse, no tx_error.
- tx_data=0x02 → parity bit 0; tx_data=0x00 → parity bit 1. Each gives tx_done.
- Device returns ACK bit=1 → single tx_error pulse, tx_done stays 0, back to IDLE with tx_ready=1.
- Device never clocks after REQ → after TIMEOUT_CYCLES, tx_error pulses and both oe are 0.
- Glitch of FILTER_LEN−1 cycles on ps2_clk_in during SHIFT → no bit advance; the frame still completes correctly.
- reset_n asserted at bit 5 → oe=0 immediately; after release, a new 0xED accept completes normally.
